// File: rtl/accelerator_state_matrix_feedback_sum.sv
// Feedback sum F = I + D*K: buffers streamed D (p x m) and K (m x p), runs one
// fixed-point MAC per cycle and streams F row-major, one element per m+1 cycles.
module accelerator_state_matrix_feedback_sum #(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32,
  parameter int MATRIX_MAX    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic                 DATA_D_IN_I_ENABLE,
  input  logic                 DATA_D_IN_J_ENABLE,
  input  logic                 DATA_K_IN_I_ENABLE,
  input  logic                 DATA_K_IN_J_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_D_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_D_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_J_IN,
  input  logic [DATA_SIZE-1:0] DATA_D_IN,
  input  logic [DATA_SIZE-1:0] DATA_K_IN,
  output logic                 DATA_F_OUT_I_ENABLE,
  output logic                 DATA_F_OUT_J_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_F_OUT
);

  localparam int DEPTH = MATRIX_MAX * MATRIX_MAX;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic signed [DATA_SIZE-1:0] FX_ONE  = DATA_SIZE'(1) << FRACTION_SIZE;
  localparam logic        [DATA_SIZE-1:0] MAX_DIM = DATA_SIZE'(MATRIX_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, EMIT, DONE} state_t;

  state_t state, state_next;

  logic [CONTROL_SIZE-1:0] dim_m, dim_p;
  logic [CONTROL_SIZE-1:0] d_i, d_j, k_i, k_j;
  logic [CONTROL_SIZE-1:0] row, col, kk, row_next, col_next;
  logic d_done, k_done, err_flag;
  logic d_wr, k_wr, d_last, k_last, d_complete, k_complete;
  logic dims_ok, mac_last, emit_last;
  logic unused_row_marks;

  logic signed [DATA_SIZE-1:0] d_mem [DEPTH];
  logic signed [DATA_SIZE-1:0] k_mem [DEPTH];
  logic signed [DATA_SIZE-1:0] acc, acc_sum;

  function automatic logic [AW-1:0] cell_addr(input logic [CONTROL_SIZE-1:0] r,
                                               input logic [CONTROL_SIZE-1:0] c);
    return AW'(r * CONTROL_SIZE'(MATRIX_MAX) + c);
  endfunction

  function automatic logic dim_in_range(input logic [DATA_SIZE-1:0] s);
    return (s >= DATA_SIZE'(1)) && (s <= MAX_DIM);
  endfunction

  // Full-width signed product, arithmetic shift back to the Q format, then wrap.
  function automatic logic signed [DATA_SIZE-1:0] scale_product(
      input logic signed [DATA_SIZE-1:0] a,
      input logic signed [DATA_SIZE-1:0] b);
    logic signed [2*DATA_SIZE-1:0] full;
    full = (2*DATA_SIZE)'(a) * (2*DATA_SIZE)'(b);
    full = full >>> FRACTION_SIZE;
    return full[DATA_SIZE-1:0];
  endfunction

  // Row-start marks on the inputs carry no information the counters need.
  assign unused_row_marks = DATA_D_IN_I_ENABLE ^ DATA_K_IN_I_ENABLE;

  assign dims_ok = (SIZE_D_J_IN == SIZE_K_I_IN) && (SIZE_D_I_IN == SIZE_K_J_IN) &&
                   dim_in_range(SIZE_D_J_IN) && dim_in_range(SIZE_D_I_IN);

  assign d_wr       = (state == LOAD) && DATA_D_IN_J_ENABLE && !d_done;
  assign k_wr       = (state == LOAD) && DATA_K_IN_J_ENABLE && !k_done;
  assign d_last     = (d_i == dim_p - 1'b1) && (d_j == dim_m - 1'b1);
  assign k_last     = (k_i == dim_m - 1'b1) && (k_j == dim_p - 1'b1);
  assign d_complete = d_done || (d_wr && d_last);
  assign k_complete = k_done || (k_wr && k_last);

  assign mac_last  = (kk == dim_m - 1'b1);
  assign emit_last = (row == dim_p - 1'b1) && (col == dim_p - 1'b1);
  assign col_next  = (col == dim_p - 1'b1) ? '0 : col + 1'b1;
  assign row_next  = (col == dim_p - 1'b1) ? row + 1'b1 : row;

  assign acc_sum = acc + scale_product(d_mem[cell_addr(row, kk)], k_mem[cell_addr(kk, col)]);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = dims_ok ? LOAD : DONE;
      LOAD:    if (d_complete && k_complete) state_next = COMPUTE;
      COMPUTE: if (mac_last) state_next = EMIT;
      EMIT:    state_next = emit_last ? DONE : COMPUTE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state               <= IDLE;
      dim_m               <= '0;
      dim_p               <= '0;
      d_i                 <= '0;
      d_j                 <= '0;
      k_i                 <= '0;
      k_j                 <= '0;
      row                 <= '0;
      col                 <= '0;
      kk                  <= '0;
      d_done              <= 1'b0;
      k_done              <= 1'b0;
      err_flag            <= 1'b0;
      READY               <= 1'b0;
      ERROR               <= 1'b0;
      DATA_F_OUT_I_ENABLE <= 1'b0;
      DATA_F_OUT_J_ENABLE <= 1'b0;
      DATA_F_OUT          <= '0;
    end else begin
      state               <= state_next;
      READY               <= 1'b0;
      ERROR               <= 1'b0;
      DATA_F_OUT_I_ENABLE <= 1'b0;
      DATA_F_OUT_J_ENABLE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            dim_m    <= CONTROL_SIZE'(SIZE_D_J_IN);
            dim_p    <= CONTROL_SIZE'(SIZE_D_I_IN);
            err_flag <= !dims_ok;
            d_i      <= '0;
            d_j      <= '0;
            k_i      <= '0;
            k_j      <= '0;
            d_done   <= 1'b0;
            k_done   <= 1'b0;
            row      <= '0;
            col      <= '0;
            kk       <= '0;
          end
        end
        LOAD: begin
          if (d_wr) begin
            if (d_j == dim_m - 1'b1) begin
              d_j    <= '0;
              d_i    <= d_i + 1'b1;
              d_done <= d_last;
            end else begin
              d_j <= d_j + 1'b1;
            end
          end
          if (k_wr) begin
            if (k_j == dim_p - 1'b1) begin
              k_j    <= '0;
              k_i    <= k_i + 1'b1;
              k_done <= k_last;
            end else begin
              k_j <= k_j + 1'b1;
            end
          end
          row <= '0;
          col <= '0;
          kk  <= '0;
        end
        COMPUTE: begin
          if (mac_last) begin
            kk                  <= '0;
            DATA_F_OUT          <= acc_sum;
            DATA_F_OUT_J_ENABLE <= 1'b1;
            DATA_F_OUT_I_ENABLE <= (col == '0);
          end else begin
            kk <= kk + 1'b1;
          end
        end
        EMIT: begin
          row   <= row_next;
          col   <= col_next;
          READY <= emit_last;
        end
        // The error path reports on the way out of DONE so it lands two cycles after START.
        DONE: begin
          READY <= err_flag;
          ERROR <= err_flag;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (d_wr) d_mem[cell_addr(d_i, d_j)] <= DATA_D_IN;
    if (k_wr) k_mem[cell_addr(k_i, k_j)] <= DATA_K_IN;
    if (state == COMPUTE)
      acc <= acc_sum;
    else if (state_next == COMPUTE)
      acc <= ((state == LOAD) || (row_next == col_next)) ? FX_ONE : '0;
  end

endmodule

// File: tb/tb_accelerator_state_matrix_feedback_sum.sv
// Scoreboard bench: stimulus pushes expected F elements and READY events, monitors pop and compare.
module tb_accelerator_state_matrix_feedback_sum;

  logic clk, rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [63:0] data;
    logic        ien;
    int          at;
  } f_exp_t;

  typedef struct {
    logic err;
    int   at;
  } r_exp_t;

  f_exp_t fq_int[$];
  f_exp_t fq_fx[$];
  r_exp_t rq_int[$];
  r_exp_t rq_fx[$];
  f_exp_t mon_int_f, mon_fx_f;
  r_exp_t mon_int_r, mon_fx_r;

  // Integer-mode instance
  logic        intm_start, intm_d_ien, intm_d_jen, intm_k_ien, intm_k_jen;
  logic [63:0] intm_di, intm_dj, intm_ki, intm_kj, intm_d, intm_k;
  logic        intm_ready, intm_error, intm_f_ien, intm_f_jen;
  logic [63:0] intm_f;

  // Q32.32 instance
  logic        fxm_start, fxm_d_ien, fxm_d_jen, fxm_k_ien, fxm_k_jen;
  logic [63:0] fxm_di, fxm_dj, fxm_ki, fxm_kj, fxm_d, fxm_k;
  logic        fxm_ready, fxm_error, fxm_f_ien, fxm_f_jen;
  logic [63:0] fxm_f;

  accelerator_state_matrix_feedback_sum #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .FRACTION_SIZE(0), .MATRIX_MAX(4)
  ) dut_int (
    .CLK(clk), .RST(rst), .START(intm_start), .READY(intm_ready), .ERROR(intm_error),
    .DATA_D_IN_I_ENABLE(intm_d_ien), .DATA_D_IN_J_ENABLE(intm_d_jen),
    .DATA_K_IN_I_ENABLE(intm_k_ien), .DATA_K_IN_J_ENABLE(intm_k_jen),
    .SIZE_D_I_IN(intm_di), .SIZE_D_J_IN(intm_dj), .SIZE_K_I_IN(intm_ki), .SIZE_K_J_IN(intm_kj),
    .DATA_D_IN(intm_d), .DATA_K_IN(intm_k),
    .DATA_F_OUT_I_ENABLE(intm_f_ien), .DATA_F_OUT_J_ENABLE(intm_f_jen), .DATA_F_OUT(intm_f)
  );

  accelerator_state_matrix_feedback_sum #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .FRACTION_SIZE(32), .MATRIX_MAX(4)
  ) dut_fx (
    .CLK(clk), .RST(rst), .START(fxm_start), .READY(fxm_ready), .ERROR(fxm_error),
    .DATA_D_IN_I_ENABLE(fxm_d_ien), .DATA_D_IN_J_ENABLE(fxm_d_jen),
    .DATA_K_IN_I_ENABLE(fxm_k_ien), .DATA_K_IN_J_ENABLE(fxm_k_jen),
    .SIZE_D_I_IN(fxm_di), .SIZE_D_J_IN(fxm_dj), .SIZE_K_I_IN(fxm_ki), .SIZE_K_J_IN(fxm_kj),
    .DATA_D_IN(fxm_d), .DATA_K_IN(fxm_k),
    .DATA_F_OUT_I_ENABLE(fxm_f_ien), .DATA_F_OUT_J_ENABLE(fxm_f_jen), .DATA_F_OUT(fxm_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=present expected=none (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors
  always @(negedge clk) begin
    if (intm_f_jen) begin
      if (fq_int.size() == 0) flag_unexpected("int_f_unexpected");
      else begin
        mon_int_f = fq_int.pop_front();
        check("int_f_data", intm_f, mon_int_f.data);
        check("int_f_ien", 64'(intm_f_ien), 64'(mon_int_f.ien));
        check("int_f_cycle", 64'(cyc), 64'(mon_int_f.at));
      end
    end else if (intm_f_ien) flag_unexpected("int_ien_without_jen");
    if (intm_ready) begin
      if (rq_int.size() == 0) flag_unexpected("int_ready_unexpected");
      else begin
        mon_int_r = rq_int.pop_front();
        check("int_error", 64'(intm_error), 64'(mon_int_r.err));
        check("int_ready_cycle", 64'(cyc), 64'(mon_int_r.at));
      end
    end else if (intm_error) flag_unexpected("int_error_without_ready");
  end

  always @(negedge clk) begin
    if (fxm_f_jen) begin
      if (fq_fx.size() == 0) flag_unexpected("fx_f_unexpected");
      else begin
        mon_fx_f = fq_fx.pop_front();
        check("fx_f_data", fxm_f, mon_fx_f.data);
        check("fx_f_ien", 64'(fxm_f_ien), 64'(mon_fx_f.ien));
        check("fx_f_cycle", 64'(cyc), 64'(mon_fx_f.at));
      end
    end
    if (fxm_ready) begin
      if (rq_fx.size() == 0) flag_unexpected("fx_ready_unexpected");
      else begin
        mon_fx_r = rq_fx.pop_front();
        check("fx_error", 64'(fxm_error), 64'(mon_fx_r.err));
        check("fx_ready_cycle", 64'(cyc), 64'(mon_fx_r.at));
      end
    end
  end

  task automatic int_start(input logic [63:0] di, input logic [63:0] dj,
                           input logic [63:0] ki, input logic [63:0] kj, output int t0);
    intm_di = di; intm_dj = dj; intm_ki = ki; intm_kj = kj;
    intm_start = 1'b1;
    t0 = cyc;
    tick();
    intm_start = 1'b0;
  endtask

  task automatic int_clear_enables();
    intm_d_jen = 1'b0; intm_k_jen = 1'b0; intm_d_ien = 1'b0; intm_k_ien = 1'b0;
  endtask

  // D = [[1,2],[3,4]], K = identity, both streamed together.
  task automatic int_load_2x2(output int l);
    for (int idx = 0; idx < 4; idx++) begin
      intm_d_jen = 1'b1; intm_k_jen = 1'b1;
      intm_d_ien = (idx % 2 == 0); intm_k_ien = (idx % 2 == 0);
      intm_d = 64'(idx + 1);
      intm_k = (idx == 0 || idx == 3) ? 64'd1 : 64'd0;
      l = cyc;
      tick();
    end
    int_clear_enables();
  endtask

  // F = I + D = [[2,2],[3,5]], one element per 3 cycles after L.
  task automatic int_expect_2x2(input int l);
    logic [63:0] vals [4];
    vals = '{64'd2, 64'd2, 64'd3, 64'd5};
    for (int e = 0; e < 4; e++)
      fq_int.push_back('{data: vals[e], ien: (e % 2 == 0), at: l + 3 * (e + 1)});
    rq_int.push_back('{err: 1'b0, at: l + 13});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, l;
    rst = 1'b1;
    intm_start = 0; intm_di = 0; intm_dj = 0; intm_ki = 0; intm_kj = 0; intm_d = 0; intm_k = 0;
    int_clear_enables();
    fxm_start = 0; fxm_di = 0; fxm_dj = 0; fxm_ki = 0; fxm_kj = 0; fxm_d = 0; fxm_k = 0;
    fxm_d_jen = 0; fxm_k_jen = 0; fxm_d_ien = 0; fxm_k_ien = 0;
    tick();
    tick();
    check("rst_ready", 64'(intm_ready), 64'd0);
    check("rst_error", 64'(intm_error), 64'd0);
    check("rst_f_ien", 64'(intm_f_ien), 64'd0);
    check("rst_f_jen", 64'(intm_f_jen), 64'd0);
    check("rst_f_data", intm_f, 64'd0);
    check("rst_fx_f_data", fxm_f, 64'd0);
    rst = 1'b0;
    tick();

    // Integer 2x2, concurrent load
    int_start(64'd2, 64'd2, 64'd2, 64'd2, t0);
    int_load_2x2(l);
    int_expect_2x2(l);
    repeat (15) tick();

    // Q32.32, p=1, m=2: 0.5*2 + 0.25*4 + 1 = 3.0
    fxm_di = 64'd1; fxm_dj = 64'd2; fxm_ki = 64'd2; fxm_kj = 64'd1;
    fxm_start = 1'b1;
    tick();
    fxm_start = 1'b0;
    fxm_d_jen = 1'b1; fxm_k_jen = 1'b1; fxm_d_ien = 1'b1; fxm_k_ien = 1'b1;
    fxm_d = 64'h0000_0000_8000_0000; fxm_k = 64'h0000_0002_0000_0000;
    tick();
    fxm_d_ien = 1'b0; fxm_k_ien = 1'b1;
    fxm_d = 64'h0000_0000_4000_0000; fxm_k = 64'h0000_0004_0000_0000;
    l = cyc;
    tick();
    fxm_d_jen = 1'b0; fxm_k_jen = 1'b0; fxm_d_ien = 1'b0; fxm_k_ien = 1'b0;
    fq_fx.push_back('{data: 64'h0000_0003_0000_0000, ien: 1'b1, at: l + 3});
    rq_fx.push_back('{err: 1'b0, at: l + 4});
    repeat (8) tick();

    // Staggered: K, then a gap with surplus K pulses, then D, then surplus pulses in COMPUTE
    int_start(64'd2, 64'd2, 64'd2, 64'd2, t0);
    for (int idx = 0; idx < 4; idx++) begin
      intm_k_jen = 1'b1; intm_k_ien = (idx % 2 == 0);
      intm_k = (idx == 0 || idx == 3) ? 64'd1 : 64'd0;
      tick();
    end
    int_clear_enables();
    for (int g = 0; g < 5; g++) begin
      intm_k_jen = (g < 2); intm_k = 64'd99;
      tick();
    end
    int_clear_enables();
    for (int idx = 0; idx < 4; idx++) begin
      intm_d_jen = 1'b1; intm_d_ien = (idx % 2 == 0);
      intm_d = 64'(idx + 1);
      l = cyc;
      tick();
    end
    int_clear_enables();
    int_expect_2x2(l);
    for (int g = 0; g < 2; g++) begin
      intm_d_jen = 1'b1; intm_k_jen = 1'b1; intm_d = 64'd77; intm_k = 64'd77;
      tick();
    end
    int_clear_enables();
    repeat (13) tick();

    // Dimension errors: inner mismatch, then p above MATRIX_MAX
    int_start(64'd2, 64'd2, 64'd3, 64'd2, t0);
    rq_int.push_back('{err: 1'b1, at: t0 + 2});
    repeat (4) tick();
    int_start(64'd5, 64'd2, 64'd2, 64'd5, t0);
    rq_int.push_back('{err: 1'b1, at: t0 + 2});
    repeat (4) tick();

    // Negative wrap: 1 + (-3 * 5) = -14
    int_start(64'd1, 64'd1, 64'd1, 64'd1, t0);
    intm_d_jen = 1'b1; intm_k_jen = 1'b1; intm_d_ien = 1'b1; intm_k_ien = 1'b1;
    intm_d = 64'hFFFF_FFFF_FFFF_FFFD; intm_k = 64'd5;
    l = cyc;
    tick();
    int_clear_enables();
    fq_int.push_back('{data: 64'hFFFF_FFFF_FFFF_FFF2, ien: 1'b1, at: l + 2});
    rq_int.push_back('{err: 1'b0, at: l + 3});
    repeat (6) tick();

    // Asynchronous reset in the middle of COMPUTE
    int_start(64'd2, 64'd2, 64'd2, 64'd2, t0);
    int_load_2x2(l);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(intm_ready), 64'd0);
    check("midrst_error", 64'(intm_error), 64'd0);
    check("midrst_f_ien", 64'(intm_f_ien), 64'd0);
    check("midrst_f_jen", 64'(intm_f_jen), 64'd0);
    check("midrst_f_data", intm_f, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Full rerun after reset, with START and D pulses landing during EMIT
    int_start(64'd2, 64'd2, 64'd2, 64'd2, t0);
    int_load_2x2(l);
    int_expect_2x2(l);
    tick();
    tick();
    intm_start = 1'b1; intm_di = 64'd1; intm_dj = 64'd1; intm_ki = 64'd1; intm_kj = 64'd1;
    intm_d_jen = 1'b1; intm_d = 64'd555;
    tick();
    intm_start = 1'b0;
    int_clear_enables();
    repeat (14) tick();

    repeat (3) tick();
    check("int_f_queue_drained", 64'(fq_int.size()), 64'd0);
    check("int_ready_queue_drained", 64'(rq_int.size()), 64'd0);
    check("fx_f_queue_drained", 64'(fq_fx.size()), 64'd0);
    check("fx_ready_queue_drained", 64'(rq_fx.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
